// File: rtl/parity_frame_checker.sv
// Multi-channel serial parity frame checker: WORD_W data bits (LSB first) then one parity bit
// per frame, with per-frame pass/fail pulses, Mealy running parity and saturating error counters.
module parity_frame_checker #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode_odd,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       bit_valid,
  input  logic [CHANNELS-1:0]       bit_in,
  output logic [CHANNELS-1:0]       running_parity,
  output logic [CHANNELS-1:0]       word_done,
  output logic [CHANNELS-1:0]       parity_err,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] err_count
);

  localparam int unsigned CntBits = $clog2(WORD_W + 1);
  localparam logic [CntBits-1:0] LastData = CntBits'(WORD_W - 1);

  typedef enum logic [0:0] {StData, StPar} state_e;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [CntBits-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]     ecnt_q, ecnt_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 busy_q;

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ecnt_d  = ecnt_q;
      done_d  = 1'b0;
      perr_d  = 1'b0;
      if (clear) begin
        // Clear wins over any bit accepted this cycle, parity bit included.
        state_d = StData;
        acc_d   = 1'b0;
        cnt_d   = '0;
        ecnt_d  = '0;
      end else if (bit_valid[c]) begin
        unique case (state_q)
          StData: begin
            acc_d = acc_q ^ bit_in[c];
            cnt_d = cnt_q + CntBits'(1);
            if (cnt_q == LastData) begin
              state_d = StPar;
            end
          end
          StPar: begin
            done_d  = 1'b1;
            perr_d  = (acc_q ^ bit_in[c]) != mode_odd;
            acc_d   = 1'b0;
            cnt_d   = '0;
            state_d = StData;
            if (perr_d && (ecnt_q != {CNT_W{1'b1}})) begin
              ecnt_d = ecnt_q + CNT_W'(1);
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StData;
        acc_q   <= 1'b0;
        cnt_q   <= '0;
        ecnt_q  <= '0;
        done_q  <= 1'b0;
        perr_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        ecnt_q  <= ecnt_d;
        done_q  <= done_d;
        perr_q  <= perr_d;
        busy_q  <= (cnt_d != '0);
      end
    end

    assign running_parity[c]             = acc_q ^ (bit_valid[c] & bit_in[c]);
    assign word_done[c]                  = done_q;
    assign parity_err[c]                 = perr_q;
    assign busy[c]                       = busy_q;
    assign err_count[c*CNT_W +: CNT_W]   = ecnt_q;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Multi-channel, parametrised successor to the single-bit serial parity Mealy checker.
- Each channel receives a serial stream framed as WORD_W data bits followed by one parity bit, with per-bit valid qualification.
- Even/odd parity is selectable. Outputs: per-frame pass/fail, a Mealy running-parity output, and saturating error counters.
- Sits between the serial deserialiser front-end and the link-status/CSR block.

Parameters:
- CHANNELS, 4, number of independent serial channels.
- WORD_W, 8, data bits per frame, excluding the parity bit; legal range ≥2.
- CNT_W, 8, width of each per-channel error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode_odd  input  1  parity mode: 0 = even (data+parity has an even number of ones), 1 = odd; sampled on each parity-bit cycle.
- clear  input  1  synchronous clear: aborts in-flight frames and zeroes the counters.
- bit_valid  input  CHANNELS  per-channel qualifier for bit_in.
- bit_in  input  CHANNELS  per-channel serial data bit; data bits are LSB first, then the parity bit.
- running_parity  output  CHANNELS  Mealy output = acc[c] ^ (bit_valid[c] & bit_in[c]); combinational.
- word_done  output  CHANNELS  registered 1-cycle pulse after a parity bit is accepted.
- parity_err  output  CHANNELS  registered; valid while word_done is high, else 0.
- busy  output  CHANNELS  registered; 1 when the channel is mid-frame (bit_cnt != 0).
- err_count  output  CHANNELS*CNT_W  per-channel saturating error counters; channel c occupies [c*CNT_W +: CNT_W].

Behaviour:
- Per channel, independent state:
  - acc: 1-bit running XOR.
  - bit_cnt: 0..WORD_W, width clog2(WORD_W+1).
  - Two-phase FSM:
    - DATA (bit_cnt < WORD_W).
    - PAR (bit_cnt == WORD_W).
- Reset (async) values:
  - acc = 0, bit_cnt = 0 (DATA), busy = 0.
  - word_done = 0, parity_err = 0, err_count = 0.
  - running_parity then equals bit_valid & bit_in.
- bit_valid[c] = 0:
  - Channel holds all state.
  - Gaps of any length between bits are legal.
- DATA state with valid bit:
  - acc <= acc ^ bit_in.
  - bit_cnt <= bit_cnt + 1.
  - After WORD_W accepted bits, the FSM moves to PAR.
- PAR state with valid bit:
  - total = acc ^ bit_in.
  - Error when total != mode_odd.
  - Next cycle: word_done = 1 and parity_err = error.
  - acc <= 0, bit_cnt <= 0 (back to DATA).
  - If error, err_count increments, saturating at 2^CNT_W-1 with no wrap.
- Latency: parity bit accepted at cycle N → word_done/parity_err high in cycle N+1 only. Back-to-back frames with no idle cycle are supported.
- running_parity is pure Mealy and changes within the cycle as bit_in changes. It is not registered and has no reset dependency beyond acc.
- busy = (bit_cnt != 0), registered alongside bit_cnt.
- mode_odd:
  - Only its value in the parity-bit cycle matters.
  - Mid-frame changes are legal and do not corrupt acc.
- clear = 1 (synchronous, all channels):
  - acc <= 0, bit_cnt <= 0, err_count <= 0.
  - word_done <= 0, parity_err <= 0.
  - Any valid bit in the same cycle, including a parity bit, is discarded: no word_done, no count.
  - clear takes precedence over every other event.
- Async reset mid-frame: the partial frame is lost, and the next valid bit is treated as data bit 0.
- Channels share no state apart from clear, mode_odd and reset.

Test Plan:
- Even mode, ch0, WORD_W=8: data 0xA5 LSB-first, then parity 0 → word_done[0] 1 cycle later, parity_err[0]=0, err_count[0]=0.
- Even mode, ch1: data 0x07, then parity 0 → parity_err[1]=1, err_count[1]=1. Repeat with mode_odd=1 and parity 0 → no error; err_count[1] stays 1.
- Gapped input, ch2: 0xA5 with bit_valid low 3 cycles between every bit. running_parity[2] checked every cycle, e.g. after bits 1,0,1 with bit_in=0 valid → 0. Frame completes with no error; busy high from bit 1 until the parity cycle.
- Saturation, CNT_W=2, ch3: 5 consecutive bad frames back-to-back → err_count[3] = 1,2,3,3,3. word_done[3] pulses each frame with no idle cycle.
- Precedence and abort:
  - Assert clear in the ch0 parity-bit cycle → no word_done, err_count zeroed, busy=0.
  - Assert reset after 4 data bits on ch1 → busy=0.
  - After either, a following full 0x0F frame with parity 0 passes.
- Independence: all 4 channels run staggered frames simultaneously with mixed good/bad parity → each err_count matches its own bad-frame tally.
